// File: rtl/fa_pkg.sv
// Shared types and helpers for the chunk-serial adder.
// FSM state encoding, counter sizing and parameter legality.
package fa_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit fa_legal(
    input int w,
    input int c
  );
    return (c >= 1) && (c <= w) && (w % c == 0);
  endfunction

endpackage

// File: rtl/fa_chunk_serial_if.sv
// Operand/result handshake bundle for fa_chunk_serial.
// master drives the request, slave returns status and result.
interface fa_chunk_serial_if #(
  parameter int WIDTH = 16
);
  import fa_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co, ovf
  );

endinterface

// File: rtl/fa_chunk.sv
// Combinational CHUNK-bit adder slice: {co, s} = a + b + ci.
// One instance is time-shared across all chunks.
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b}
                 + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/fa_chunk_serial.sv
// Multi-cycle adder, CHUNK bits per clock, LSB chunk first.
// FA_SERIAL_OVF_EN builds the signed-overflow output.
module fa_chunk_serial
  import fa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic               clk,
  input logic               rst,
  fa_chunk_serial_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_w(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (!fa_legal(WIDTH, CHUNK)) begin : g_bad
    $error("fa_chunk_serial: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             ovf_q;
  logic             done_q;

  int               idx;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cc;

  assign idx = int'(cnt) * CHUNK;
  assign ca  = a_q[idx +: CHUNK];
  assign cb  = b_q[idx +: CHUNK];

  fa_chunk #(
    .CHUNK (CHUNK)
  ) u_add (
    .a  (ca),
    .b  (cb),
    .ci (carry),
    .s  (cs),
    .co (cc)
  );

  // Final edge must publish the chunk being added in that same cycle.
  always_comb begin
    res_nxt = res;
    res_nxt[idx +: CHUNK] = cs;
  end

`ifdef FA_SERIAL_OVF_EN
  logic c_msb;
  logic ovf_nxt;
  // Carry into the MSB recovered from the MSB sum bit.
  assign c_msb   = cs[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
  assign ovf_nxt = c_msb ^ cc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res    <= '0;
      carry  <= 1'b0;
      s_q    <= '0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= bus.ci;
            cnt   <= '0;
            state <= RUN;
          end
        end
        (state == RUN): begin
          res   <= res_nxt;
          carry <= cc;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            s_q    <= res_nxt;
            co_q   <= cc;
`ifdef FA_SERIAL_OVF_EN
            ovf_q  <= ovf_nxt;
`else
            ovf_q  <= 1'b0;
`endif
            done_q <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;

endmodule
